// File: rtl/alu_arbiter.sv
// Round-robin sequencer sharing one combinational ALU between two requesters.
// Define ALU_ARB_FIXED_PRIO_EN to make req0 win every tie (req1 may starve).
module alu_arbiter #(
    parameter int WIDTH = 4,
    parameter int SEL_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [SEL_W-1:0] req0_s,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [SEL_W-1:0] req1_s,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [SEL_W-1:0] alu_s,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_y,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_y,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic [SEL_W-1:0] s_q, s_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             id_q, id_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             busy_q, busy_d;
    logic             grant1;
    logic             any_valid;

    always_comb begin
        any_valid = req0_valid | req1_valid;
`ifdef ALU_ARB_FIXED_PRIO_EN
        grant1 = req1_valid & ~req0_valid;
`else
        // On a tie the requester that was not served last wins.
        grant1 = req1_valid & (~req0_valid | ~last_q);
`endif
    end

    assign req0_ready = (state_q == IDLE) & ~rst & req0_valid & ~grant1;
    assign req1_ready = (state_q == IDLE) & ~rst & grant1;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        s_d         = s_q;
        a_d         = a_q;
        b_d         = b_q;
        y_d         = y_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        busy_d      = busy_q;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    id_d    = grant1;
                    last_d  = grant1;
                    s_d     = grant1 ? req1_s : req0_s;
                    a_d     = grant1 ? req1_a : req0_a;
                    b_d     = grant1 ? req1_b : req0_b;
                    state_d = ISSUE;
                    busy_d  = 1'b1;
                end
            end
            ISSUE: begin
                y_d         = alu_y;
                state_d     = RESP;
                rsp_valid_d = 1'b1;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            s_q         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            y_q         <= '0;
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            s_q         <= s_d;
            a_q         <= a_d;
            b_q         <= b_d;
            y_q         <= y_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign alu_s     = s_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = id_q;
    assign rsp_y     = y_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: transaction-level model plus directed literal checks.
module tb_alu_arbiter;

    logic       clk, rst;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [1:0] req0_s, req1_s, alu_s;
    logic [3:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_y, rsp_y;
    logic       rsp_valid, rsp_ready, rsp_id, busy;

    int checks = 0;
    int passes = 0;

    alu_arbiter #(.WIDTH(4), .SEL_W(2)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_s(req0_s), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_s(req1_s), .req1_a(req1_a), .req1_b(req1_b),
        .alu_s(alu_s), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_y(rsp_y), .busy(busy)
    );

    function automatic logic [3:0] alu_f(input logic [1:0] s, input logic [3:0] a, input logic [3:0] b);
        int r;
        case (s)
            2'd0:    r = a & b;
            2'd1:    r = (int'(a) + int'(b)) % 16;
            2'd2:    r = a | b;
            default: r = a ^ b;
        endcase
        return r[3:0];
    endfunction

    assign alu_y = alu_f(alu_s, alu_a, alu_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: phase 0 idle, 1 ALU issue, 2 response pending.
    typedef struct packed { logic id; logic [3:0] y; } rsp_t;
    rsp_t       exp_q[$];
    int         m_phase = 0;
    int         m_last  = 1;
    logic [1:0] m_s = 0;
    logic [3:0] m_a = 0, m_b = 0, m_y = 0;
    logic       m_id = 0;
    logic       acc0 = 0, acc1 = 0;

    always @(negedge clk) begin
        int   w;
        rsp_t e;
        if (rst) begin
            m_phase = 0; m_last = 1; m_s = 0; m_a = 0; m_b = 0; m_y = 0; m_id = 0;
            exp_q.delete();
        end
        if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            w = 0;
`else
            w = 1 - m_last;
`endif
        end else if (req0_valid) w = 0;
        else if (req1_valid) w = 1;
        else w = -1;
        chk("m_ready0",    req0_ready, (!rst && m_phase == 0 && w == 0));
        chk("m_ready1",    req1_ready, (!rst && m_phase == 0 && w == 1));
        chk("m_busy",      busy,       (m_phase != 0));
        chk("m_rsp_valid", rsp_valid,  (m_phase == 2));
        chk("m_alu_s",     alu_s,      m_s);
        chk("m_alu_a",     alu_a,      m_a);
        chk("m_alu_b",     alu_b,      m_b);
        chk("m_rsp_id",    rsp_id,     m_id);
        chk("m_rsp_y",     rsp_y,      m_y);
        acc0 = req0_valid && req0_ready;
        acc1 = req1_valid && req1_ready;
        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) chk("sb_unexpected_rsp", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("sb_rsp_id", rsp_id, e.id);
                chk("sb_rsp_y",  rsp_y,  e.y);
            end
        end
        if (!rst) begin
            case (m_phase)
                0: if (w >= 0) begin
                    m_s  = (w == 1) ? req1_s : req0_s;
                    m_a  = (w == 1) ? req1_a : req0_a;
                    m_b  = (w == 1) ? req1_b : req0_b;
                    m_id = (w == 1);
                    m_last = w;
                    e.id = (w == 1);
                    e.y  = alu_f(m_s, m_a, m_b);
                    exp_q.push_back(e);
                    m_phase = 1;
                end
                1: begin m_y = alu_f(m_s, m_a, m_b); m_phase = 2; end
                default: if (rsp_ready) m_phase = 0;
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(); rst = 1'b1;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 20) begin step(); n++; end
        if (busy) chk("wait_idle_timeout", 1, 0);
    endtask

    initial begin
        int         grants[4];
        int         ng, nr, k;
        logic [3:0] r_y[2];
        logic       r_id[2];
        logic [3:0] hold_y;
        logic       hold_id;

        rst = 1'b1; rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_s = 0; req0_a = 0; req0_b = 0;
        req1_valid = 1'b1; req1_s = 0; req1_a = 0; req1_b = 0;
        step(); step(); #1;
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_alu_a", alu_a, 0);
        req0_valid = 0; req1_valid = 0;
        step(); rst = 1'b0;

        // Single request
        step();
        req0_valid = 1; req0_s = 2'b01; req0_a = 4'b1011; req0_b = 4'b0011; rsp_ready = 1;
        #1;
        chk("single_ready0", req0_ready, 1);
        chk("single_ready1", req1_ready, 0);
        step(); req0_valid = 0; #1;
        chk("single_alu_s", alu_s, 2'b01);
        chk("single_alu_a", alu_a, 4'b1011);
        chk("single_alu_b", alu_b, 4'b0011);
        chk("single_busy1", busy, 1);
        chk("single_rspv1", rsp_valid, 0);
        step(); #1;
        chk("single_rspv2", rsp_valid, 1);
        chk("single_id", rsp_id, 0);
        chk("single_y", rsp_y, 4'b1110);
        chk("single_busy2", busy, 1);
        step(); #1;
        chk("single_busy3", busy, 0);

        // Ties after reset
        do_reset();
        step();
        req0_valid = 1; req0_s = 1; req0_a = 4'b0001; req0_b = 4'b0001;
        req1_valid = 1; req1_s = 1; req1_a = 4'b0100; req1_b = 4'b0100;
        rsp_ready = 1;
        ng = 0; nr = 0; k = 0;
        while (ng < 4 && k < 30) begin
            #1;
            if (req0_ready) begin grants[ng] = 0; ng++; end
            else if (req1_ready) begin grants[ng] = 1; ng++; end
            if (rsp_valid && nr < 2) begin r_y[nr] = rsp_y; r_id[nr] = rsp_id; nr++; end
            step(); k++;
        end
        chk("tie_grant_count", ng, 4);
`ifdef ALU_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++) chk("tie_fixed_grant", grants[i], 0);
        chk("tie_rsp0_y", r_y[0], 4'b0010);
        chk("tie_rsp1_y", r_y[1], 4'b0010);
`else
        for (int i = 0; i < 4; i++) chk("tie_rr_grant", grants[i], i % 2);
        chk("tie_rsp0_y", r_y[0], 4'b0010);
        chk("tie_rsp0_id", r_id[0], 0);
        chk("tie_rsp1_y", r_y[1], 4'b1000);
        chk("tie_rsp1_id", r_id[1], 1);
`endif
        req0_valid = 0; req1_valid = 0;
        wait_idle();

        // Backpressure
        step();
        req0_valid = 1; req0_s = 2; req0_a = 4'h5; req0_b = 4'h8; rsp_ready = 0;
        step();
        req0_valid = 0; req1_valid = 1; req1_s = 0; req1_a = 4'hF; req1_b = 4'h6;
        step(); #1;
        chk("bp_rspv", rsp_valid, 1);
        chk("bp_y", rsp_y, 4'hD);
        hold_y = rsp_y; hold_id = rsp_id;
        for (int i = 0; i < 4; i++) begin
            step(); #1;
            chk("bp_hold_v", rsp_valid, 1);
            chk("bp_hold_y", rsp_y, hold_y);
            chk("bp_hold_id", rsp_id, hold_id);
            chk("bp_ready1", req1_ready, 0);
        end
        step(); rsp_ready = 1; #1;
        chk("bp_ready1_release", req1_ready, 0);
        step(); #1;
        chk("bp_idle", busy, 0);
        chk("bp_next_accept", req1_ready, 1);
        step(); req1_valid = 0;
        wait_idle();

        // Wrap-around
        step();
        req1_valid = 1; req1_s = 1; req1_a = 4'b1111; req1_b = 4'b0010;
        step(); req1_valid = 0;
        step(); #1;
        chk("wrap_v", rsp_valid, 1);
        chk("wrap_y", rsp_y, 4'b0001);
        chk("wrap_id", rsp_id, 1);
        wait_idle();

        // Reset during ISSUE
        step();
        req0_valid = 1; req0_s = 1; req0_a = 4'h3; req0_b = 4'h4;
        step(); req0_valid = 0; #1;
        chk("mid_issue_busy", busy, 1);
        rst = 1; #1;
        chk("mid_busy", busy, 0);
        chk("mid_alu_s", alu_s, 0);
        chk("mid_alu_a", alu_a, 0);
        chk("mid_alu_b", alu_b, 0);
        chk("mid_rspv", rsp_valid, 0);
        chk("mid_rsp_y", rsp_y, 0);
        chk("mid_rsp_id", rsp_id, 0);
        req0_valid = 1; req1_valid = 1; #1;
        chk("mid_ready0_in_rst", req0_ready, 0);
        for (int i = 0; i < 3; i++) begin
            step(); #1;
            chk("mid_no_rsp", rsp_valid, 0);
        end
        step(); rst = 0; #1;
        chk("mid_tie_ready0", req0_ready, 1);
        chk("mid_tie_ready1", req1_ready, 0);
        step(); req0_valid = 0; req1_valid = 0;
        wait_idle();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step();
            if (!req0_valid || acc0) begin
                req0_valid = ($urandom_range(2) != 0);
                req0_s = 2'($urandom); req0_a = 4'($urandom); req0_b = 4'($urandom);
            end
            if (!req1_valid || acc1) begin
                req1_valid = ($urandom_range(2) != 0);
                req1_s = 2'($urandom); req1_a = 4'($urandom); req1_b = 4'($urandom);
            end
            rsp_ready = ($urandom_range(3) != 0);
        end
        step();
        req0_valid = 0; req1_valid = 0; rsp_ready = 1;
        wait_idle();
        step(); step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
